// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM bus controller: FSM states, requester index and
// the one-hot helper used to build per-requester strobes.
package sram_ctrl_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef logic req_idx_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
    logic [NUM_REQ-1:0] oh;
    oh      = {NUM_REQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: on a tie the port that did not win last time
// is chosen. Purely combinational; the caller owns the LastGrant register.
module rr_arbiter_2
  import sram_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] Req,
  input  req_idx_t           LastGrant,
  output req_idx_t           Grant,
  output logic               Valid
);

  // Winner selection
  always_comb begin
    Grant = 1'b0;
    Valid = 1'b0;
    case (Req)
      2'b01: begin
        Grant = 1'b0;
        Valid = 1'b1;
      end
      2'b10: begin
        Grant = 1'b1;
        Valid = 1'b1;
      end
      2'b11: begin
        Grant = ~LastGrant;
        Valid = 1'b1;
      end
      default: begin
        Grant = 1'b0;
        Valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sram_bus_controller_chk.sv
// Protocol checker for the SRAM bus controller: bus contention, strobe
// consistency and Ack exclusivity.
module sram_bus_controller_chk
  import sram_ctrl_pkg::*;
(
  input logic               Clk,
  input logic               Reset,
  input logic               SRAM_CE_N,
  input logic               SRAM_OE_N,
  input logic               SRAM_WE_N,
  input logic               BusWriteEnable,
  input logic [NUM_REQ-1:0] Ack
);

  a_no_contention: assert property (@(posedge Clk) disable iff (Reset)
    !(BusWriteEnable && !SRAM_OE_N));

  a_we_needs_ce: assert property (@(posedge Clk) disable iff (Reset)
    !SRAM_WE_N |-> !SRAM_CE_N);

  // A write strobe without the buffer driving would store floating data.
  a_we_needs_drive: assert property (@(posedge Clk) disable iff (Reset)
    !SRAM_WE_N |-> BusWriteEnable);

  a_ack_onehot: assert property (@(posedge Clk) disable iff (Reset)
    $onehot0(Ack));

endmodule

// File: rtl/sram_bus_controller.sv
// Sequences the shared asynchronous SRAM bus for two requesters. All SRAM
// strobes and buffer controls are registered, decoded from the state being entered.
module sram_bus_controller
  import sram_ctrl_pkg::*;
#(
  parameter int AW          = 20,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] Req,
  input  logic [NUM_REQ-1:0] Write,
  input  logic [AW-1:0]      Addr0,
  input  logic [AW-1:0]      Addr1,
  input  logic [DW-1:0]      WData0,
  input  logic [DW-1:0]      WData1,
  output logic [NUM_REQ-1:0] Ack,
  output logic [DW-1:0]      RData0,
  output logic [DW-1:0]      RData1,
  output logic [AW-1:0]      SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               BusWriteEnable,
  output logic [DW-1:0]      BusOut,
  input  logic [DW-1:0]      BusIn
);

  localparam int            CW        = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  state_t             state_r;
  state_t             next_state_s;
  logic [CW-1:0]      wait_cnt_r;
  req_idx_t           grant_idx_r;
  req_idx_t           last_grant_r;
  req_idx_t           arb_grant_s;
  logic               arb_valid_s;
  logic               write_r;
  logic               txn_write_s;
  logic               bus_phase_s;
  logic               ce_n_s;
  logic               oe_n_s;
  logic               we_n_s;
  logic               bwe_s;
  logic [NUM_REQ-1:0] ack_s;

  rr_arbiter_2 u_arb (
    .Req       (Req),
    .LastGrant (last_grant_r),
    .Grant     (arb_grant_s),
    .Valid     (arb_valid_s)
  );

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) next_state_s = SETUP;
        else             next_state_s = IDLE;
      end
      SETUP: next_state_s = ACCESS;
      ACCESS: begin
        if (wait_cnt_r == CNT_ZERO) next_state_s = CAPTURE;
        else                        next_state_s = ACCESS;
      end
      CAPTURE: next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode; the direction comes from the arbiter on the grant edge
  always_comb begin
    if (state_r == IDLE) txn_write_s = Write[arb_grant_s];
    else                 txn_write_s = write_r;
    bus_phase_s = (next_state_s == SETUP) || (next_state_s == ACCESS) ||
                  (next_state_s == CAPTURE);
    ce_n_s = ~bus_phase_s;
    oe_n_s = ~(bus_phase_s && !txn_write_s);
    we_n_s = ~(txn_write_s && (next_state_s == ACCESS));
    bwe_s  = bus_phase_s && txn_write_s;
    if (next_state_s == DONE) ack_s = idx_to_onehot(grant_idx_r);
    else                      ack_s = {NUM_REQ{1'b0}};
  end

  // State, wait counter and SRAM/buffer control registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r        <= IDLE;
      wait_cnt_r     <= CNT_ZERO;
      SRAM_CE_N      <= 1'b1;
      SRAM_OE_N      <= 1'b1;
      SRAM_WE_N      <= 1'b1;
      BusWriteEnable <= 1'b0;
      Ack            <= {NUM_REQ{1'b0}};
    end else begin
      state_r        <= next_state_s;
      SRAM_CE_N      <= ce_n_s;
      SRAM_OE_N      <= oe_n_s;
      SRAM_WE_N      <= we_n_s;
      BusWriteEnable <= bwe_s;
      Ack            <= ack_s;
      if (state_r == SETUP) begin
        wait_cnt_r <= WAIT_LOAD;
      end else if ((state_r == ACCESS) && (wait_cnt_r != CNT_ZERO)) begin
        wait_cnt_r <= wait_cnt_r - CNT_ONE;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

  // Transaction latch on grant; LastGrant starts at 1 so port 0 wins the first tie
  always_ff @(posedge Clk) begin
    if (Reset) begin
      grant_idx_r  <= 1'b0;
      last_grant_r <= 1'b1;
      write_r      <= 1'b0;
      SRAM_ADDR    <= {AW{1'b0}};
      BusOut       <= {DW{1'b0}};
    end else if ((state_r == IDLE) && arb_valid_s) begin
      grant_idx_r  <= arb_grant_s;
      last_grant_r <= arb_grant_s;
      write_r      <= Write[arb_grant_s];
      SRAM_ADDR    <= arb_grant_s ? Addr1 : Addr0;
      BusOut       <= arb_grant_s ? WData1 : WData0;
    end else begin
      grant_idx_r  <= grant_idx_r;
      last_grant_r <= last_grant_r;
      write_r      <= write_r;
      SRAM_ADDR    <= SRAM_ADDR;
      BusOut       <= BusOut;
    end
  end

  // Read data capture; BusIn already holds the last ACCESS-cycle sample
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RData0 <= {DW{1'b0}};
      RData1 <= {DW{1'b0}};
    end else if ((state_r == CAPTURE) && !write_r) begin
      if (grant_idx_r) RData1 <= BusIn;
      else             RData0 <= BusIn;
    end else begin
      RData0 <= RData0;
      RData1 <= RData1;
    end
  end

endmodule
